oled_page_streamer: RTL
=======================

Name: oled_page_streamer

Overview:
- Upstream feeder for the I2C master. Runs after the OLED init sequence has completed.
- Holds a 128x64 monochrome framebuffer: 8 pages x 128 columns = 1024 bytes.
- On each refresh request, pushes pages to the SSD1306 as I2C transactions through a byte-level handshake with the master.
- Each page is sent as one command transaction (page/column select) followed by one data transaction (128 pixel bytes).

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit I2C address of the display.
- PAGES, 8, number of display pages.
- COLS, 128, bytes per page.

Ports:
- CLK  input  1  system clock
- NRST  input  1  asynchronous active-low reset
- start  input  1  single-cycle refresh request
- fb_we  input  1  framebuffer write strobe
- fb_addr  input  10  write address: {page[2:0], col[6:0]}
- fb_wdata  input  8  pixel byte; bit0 = top row of the page
- busy  output  1  refresh in progress
- frame_done  output  1  single-cycle pulse when a refresh completes
- error  output  1  sticky NACK flag
- m_start  output  1  single-cycle transaction request to the master
- m_slave_addr  output  7  always SLAVE_ADDR
- m_ctrl  output  8  control byte: 8'h00 for commands, 8'h40 for data
- m_byte  output  8  payload byte
- m_byte_valid  output  1  m_byte is valid
- m_byte_ready  input  1  master has taken m_byte this cycle
- m_last  output  1  m_byte is the last byte of the transaction
- m_done  input  1  pulse: master has issued STOP
- m_nack  input  1  pulse: slave NACKed

Behaviour:
Clock and reset
- Single clock CLK; NRST is asynchronous, active-low.
- Reset values: busy=0, frame_done=0, error=0, m_start=0, m_byte=0, m_byte_valid=0, m_last=0, m_ctrl=8'h00, state=IDLE, page counter=0, all dirty bits=1.
- Framebuffer RAM contents are not reset.
- Reset mid-transaction abandons the transfer immediately. The master shares NRST.

Framebuffer
- Simple dual-port RAM, 1024x8.
- Writes are accepted whenever fb_we=1, in any state.
- Read latency is 1 cycle.

Handshake
- m_byte transfers only on cycles where m_byte_valid=1 and m_byte_ready=1.
- m_byte, m_last and m_byte_valid stay stable until that transfer.
- After a data byte transfers, m_byte_valid is low for exactly 1 cycle while the RAM is read, then reasserts.
- Command bytes come from a register and are presented back-to-back.

State machine
- IDLE: start=1 -> clear error, page=0, busy=1, go to SCAN. start while busy is ignored.
- SCAN: page selected for sending -> CMD_START. Otherwise page++. After page PAGES-1 -> DONE.
- CMD_START: m_ctrl=8'h00, pulse m_start -> CMD_BYTES.
- CMD_BYTES: send 8'hB0|page, then 8'h00, then 8'h10. m_last=1 on the third byte. After the third transfer -> CMD_WAIT.
- CMD_WAIT: m_done -> DATA_START.
- DATA_START: clear dirty[page], m_ctrl=8'h40, pulse m_start, issue RAM read for col 0 -> DATA_BYTES.
- DATA_BYTES: send cols 0..COLS-1. m_last=1 on col COLS-1. Then -> DATA_WAIT.
- DATA_WAIT: m_done -> if page=PAGES-1 go to DONE, else page++ and go to SCAN.
- DONE: pulse frame_done for 1 cycle, busy=0 -> IDLE.
- Any state except IDLE/DONE, m_nack=1: drop m_byte_valid, set error=1, busy=0 -> IDLE. No frame_done. Dirty bits of unsent pages are kept.

Boundary rules
- fb_we to page p on the same cycle its dirty bit clears: the write wins, dirty[p]=1.
- Writes to a page after its DATA_START are resent on the next refresh. They may or may not appear in the current one.
- Column counter is 7 bits and stops at COLS-1; it never wraps into the next page.
- A refresh with no selected pages: frame_done is asserted 9 cycles after start (1 IDLE + 8 SCAN), with no m_start.

Optional Feature:
Macro DIRTY_TRACK_EN.
- Defined: SCAN selects only pages with dirty[page]=1. fb_we sets dirty[fb_addr[9:7]].
- Undefined: the dirty logic is omitted and SCAN selects every page, so each refresh sends all 8 pages, 8 x (3+128) bytes.

Test Plan:
- Reset, then start with an always-ready master that pulses m_done 2 cycles after each m_last transfer -> 8 command triples, the first being B0,00,10; 8x128 data bytes with m_ctrl=40; frame_done pulses once; busy is low afterwards.
- Write 8'hA5 to addr 10'h285 (page 5, col 5), then refresh (DIRTY_TRACK_EN, all other pages clean) -> only page 5 is sent: command B5,00,10; the data byte at col 5 is A5.
- Hold m_byte_ready low for 20 cycles mid-data -> m_byte/m_last stay stable; no byte is lost or duplicated; the 128-byte count is intact.
- m_nack during page 3 data -> error=1, busy=0, no frame_done. The next start clears error and resends pages 3..7 (DIRTY_TRACK_EN).
- fb_we to page 2 on the exact cycle of page 2's DATA_START -> dirty[2]=1 after the frame; the next refresh sends page 2.
- NRST asserted mid-command -> all outputs at reset values in the same cycle; start after release -> normal full refresh.

Source files
------------

// File: rtl/oled_page_streamer.sv
// Page streamer for an SSD1306 behind a byte-handshake I2C master: 1024x8 framebuffer, per-page command + data transactions.
// Define DIRTY_TRACK_EN to send only the pages written since they were last sent.
module oled_page_streamer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         PAGES      = 8,
  parameter int         COLS       = 128
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       start,
  input  logic       fb_we,
  input  logic [9:0] fb_addr,
  input  logic [7:0] fb_wdata,
  output logic       busy,
  output logic       frame_done,
  output logic       error,
  output logic       m_start,
  output logic [6:0] m_slave_addr,
  output logic [7:0] m_ctrl,
  output logic [7:0] m_byte,
  output logic       m_byte_valid,
  input  logic       m_byte_ready,
  output logic       m_last,
  input  logic       m_done,
  input  logic       m_nack
);

  localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);
  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);

  typedef enum logic [3:0] {
    IDLE, SCAN, CMD_START, CMD_BYTES, CMD_WAIT,
    DATA_START, DATA_BYTES, DATA_WAIT, DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] page_reg, page_next;
  logic [6:0] col_reg, col_next;
  logic [1:0] cmd_idx_reg, cmd_idx_next;
  logic       data_valid_reg, data_valid_next;
  logic [7:0] ctrl_reg, ctrl_next;
  logic       error_reg, error_next;
  logic       page_sel;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] mem [0:PAGES*COLS-1];

  always_ff @(posedge CLK) begin
    if (fb_we) mem[fb_addr] <= fb_wdata;
    if (rd_en) rd_data <= mem[{page_reg, col_reg}];
  end

`ifdef DIRTY_TRACK_EN
  logic [PAGES-1:0] dirty_reg;

  // An aborted data transfer leaves its page dirty; a same-cycle write always re-marks its page.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      dirty_reg <= '1;
    end else begin
      if (m_nack && busy) begin
        if (state_reg == DATA_BYTES || state_reg == DATA_WAIT) dirty_reg[page_reg] <= 1'b1;
      end else if (state_reg == DATA_START) begin
        dirty_reg[page_reg] <= 1'b0;
      end
      if (fb_we) dirty_reg[fb_addr[9:7]] <= 1'b1;
    end
  end

  assign page_sel = dirty_reg[page_reg];
`else
  assign page_sel = 1'b1;
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg      <= IDLE;
      page_reg       <= '0;
      col_reg        <= '0;
      cmd_idx_reg    <= '0;
      data_valid_reg <= 1'b0;
      ctrl_reg       <= 8'h00;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      page_reg       <= page_next;
      col_reg        <= col_next;
      cmd_idx_reg    <= cmd_idx_next;
      data_valid_reg <= data_valid_next;
      ctrl_reg       <= ctrl_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    page_next       = page_reg;
    col_next        = col_reg;
    cmd_idx_next    = cmd_idx_reg;
    data_valid_next = data_valid_reg;
    ctrl_next       = ctrl_reg;
    error_next      = error_reg;
    m_start         = 1'b0;
    m_byte_valid    = 1'b0;
    m_byte          = 8'h00;
    m_last          = 1'b0;
    frame_done      = 1'b0;
    rd_en           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          error_next = 1'b0;
          page_next  = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (page_sel) begin
          ctrl_next    = 8'h00;
          col_next     = '0;
          cmd_idx_next = '0;
          state_next   = CMD_START;
        end else if (page_reg == LAST_PAGE) begin
          state_next = DONE;
        end else begin
          page_next = page_reg + 3'd1;
        end
      end
      CMD_START: begin
        m_start    = 1'b1;
        state_next = CMD_BYTES;
      end
      CMD_BYTES: begin
        m_byte_valid = 1'b1;
        m_last       = (cmd_idx_reg == 2'd2);
        case (cmd_idx_reg)
          2'd0:    m_byte = 8'hB0 | {5'b0, page_reg};
          2'd1:    m_byte = 8'h00;
          default: m_byte = 8'h10;
        endcase
        if (m_byte_ready) begin
          if (cmd_idx_reg == 2'd2) state_next = CMD_WAIT;
          else cmd_idx_next = cmd_idx_reg + 2'd1;
        end
      end
      CMD_WAIT: begin
        if (m_done) begin
          ctrl_next  = 8'h40;
          state_next = DATA_START;
        end
      end
      DATA_START: begin
        m_start         = 1'b1;
        rd_en           = 1'b1;
        data_valid_next = 1'b1;
        state_next      = DATA_BYTES;
      end
      DATA_BYTES: begin
        // Each transfer is followed by one idle cycle that fetches the next column.
        m_byte_valid = data_valid_reg;
        m_byte       = rd_data;
        m_last       = data_valid_reg && (col_reg == LAST_COL);
        if (!data_valid_reg) begin
          rd_en           = 1'b1;
          data_valid_next = 1'b1;
        end else if (m_byte_ready) begin
          data_valid_next = 1'b0;
          if (col_reg == LAST_COL) state_next = DATA_WAIT;
          else col_next = col_reg + 7'd1;
        end
      end
      DATA_WAIT: begin
        if (m_done) begin
          if (page_reg == LAST_PAGE) begin
            state_next = DONE;
          end else begin
            page_next  = page_reg + 3'd1;
            state_next = SCAN;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (m_nack && busy) begin
      state_next      = IDLE;
      error_next      = 1'b1;
      data_valid_next = 1'b0;
      m_byte_valid    = 1'b0;
      m_last          = 1'b0;
    end
  end

  assign busy         = (state_reg != IDLE) && (state_reg != DONE);
  assign error        = error_reg;
  assign m_ctrl       = ctrl_reg;
  assign m_slave_addr = SLAVE_ADDR;

endmodule
